// File: rtl/ifid_queue.sv
// ifid_queue: DEPTH-entry in-order queue between fetch and decode.
// Decode sees a bubble (pc 0, BUBBLE_INST, pred 0) whenever the queue is empty.
module ifid_queue #(
   parameter int              XLEN        = 32,
   parameter int              DEPTH       = 4,
   parameter logic [XLEN-1:0] BUBBLE_INST = '0,
   localparam int             CW          = $clog2(DEPTH+1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_pc,
   input  logic [XLEN-1:0] f_inst,
   input  logic            f_pred,
   output logic            f_ready,
   input  logic            d_stall,
   input  logic            d_flush,
   output logic            d_valid,
   output logic [XLEN-1:0] d_pc,
   output logic [XLEN-1:0] d_inst,
   output logic            d_pred,
   output logic [CW-1:0]   count
);
   localparam int            AW   = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            pred;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          push;
   logic          pop;

   // f_ready looks only at registered occupancy, so a full queue refuses a
   // push even when decode pops in the same cycle.
   assign f_ready = (count != FULL);
   assign d_valid = (count != '0);
   assign push    = f_valid & f_ready & ~d_flush;
   assign pop     = d_valid & ~d_stall & ~d_flush;

   assign head   = mem[rd_ptr];
   assign d_pc   = d_valid ? head.pc   : '0;
   assign d_inst = d_valid ? head.inst : BUBBLE_INST;
   assign d_pred = d_valid ? head.pred : 1'b0;

   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= '{pc: f_pc, inst: f_inst, pred: f_pred};
   end

   // DEPTH is a power of two, so pointers wrap naturally; count tells full from empty.
   always_ff @(posedge clk) begin
      if (rst || d_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count <= FULL);
         assert (!(push && count == FULL));
         assert (!(pop && count == '0));
      end
   end

endmodule

// File: tb/tb_ifid_queue.sv
// Directed bench for ifid_queue: a scoreboard queue models the expected
// contents and every cycle the DUT head/occupancy is compared against it.
module tb_ifid_queue;
   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam int          CW    = $clog2(DEPTH+1);
   localparam logic [31:0] BUB   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            f_valid = 1'b0;
   logic [XLEN-1:0] f_pc = '0;
   logic [XLEN-1:0] f_inst = '0;
   logic            f_pred = 1'b0;
   logic            f_ready;
   logic            d_stall = 1'b0;
   logic            d_flush = 1'b0;
   logic            d_valid;
   logic [XLEN-1:0] d_pc;
   logic [XLEN-1:0] d_inst;
   logic            d_pred;
   logic [CW-1:0]   count;

   ent_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   stepno = 0;

   ifid_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BUBBLE_INST(BUB)) dut (
      .clk(clk), .rst(rst),
      .f_valid(f_valid), .f_pc(f_pc), .f_inst(f_inst), .f_pred(f_pred), .f_ready(f_ready),
      .d_stall(d_stall), .d_flush(d_flush),
      .d_valid(d_valid), .d_pc(d_pc), .d_inst(d_inst), .d_pred(d_pred),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s@step%0d: observed %h expected %h", tag, stepno, obs, exp);
      end
   endtask

   task automatic check_all();
      ent_t h;
      logic v;
      v = (sb.size() != 0);
      h = v ? sb[0] : '{pc: 32'h0, inst: BUB, pred: 1'b0};
      chk("count",   32'(count),   32'(sb.size()));
      chk("f_ready", 32'(f_ready), 32'(sb.size() != DEPTH));
      chk("d_valid", 32'(d_valid), 32'(v));
      chk("d_pc",    d_pc,         h.pc);
      chk("d_inst",  d_inst,       h.inst);
      chk("d_pred",  32'(d_pred),  32'(h.pred));
   endtask

   // One clock: drive at negedge, update model at posedge, check at next negedge.
   task automatic step(input logic v, input logic [31:0] pc, input logic s,
                       input logic fl, input logic r);
      ent_t e;
      logic full, do_pop, do_push;
      e.pc   = pc;
      e.inst = (pc == 32'h40) ? 32'h0050_0093 : (pc ^ 32'hA5A5_0013);
      e.pred = pc[2];
      f_valid = v; f_pc = e.pc; f_inst = e.inst; f_pred = e.pred;
      d_stall = s; d_flush = fl; rst = r;
      @(posedge clk);
      if (r || fl) begin
         sb.delete();
      end else begin
         full    = (sb.size() == DEPTH);
         do_pop  = (sb.size() != 0) && !s;
         do_push = v && !full;
         if (do_pop)  void'(sb.pop_front());
         if (do_push) sb.push_back(e);
      end
      @(negedge clk);
      stepno++;
      check_all();
   endtask

   initial begin
      // reset
      step(0, 32'h0, 0, 0, 1);
      // fill under stall, then a 5th entry that must be refused
      for (int i = 0; i < 4; i++) step(1, 32'(i*4), 1, 0, 0);
      step(1, 32'h10, 1, 0, 0);
      // drain: full cycle refuses 0x10 while popping, then push+pop coincide
      step(1, 32'h10, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 32'h10 + 32'(i*4), 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 1, 0, 0);  // stall on empty queue has no effect
      // no same-cycle bypass: previous check saw bubble, next sees 0x40
      step(1, 32'h40, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      // flush with concurrent push of wrong-path 0x80
      step(1, 32'h50, 1, 0, 0);
      step(1, 32'h54, 1, 0, 0);
      step(1, 32'h58, 1, 0, 0);
      step(1, 32'h80, 0, 1, 0);
      step(1, 32'h100, 1, 0, 0);
      step(1, 32'h104, 1, 0, 0);
      // stall hold for 5 cycles, then release
      for (int i = 0; i < 5; i++) step(0, 32'h0, 1, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      // reset mid-operation with coincident push and flush
      step(1, 32'h200, 1, 0, 0);
      step(1, 32'h204, 1, 0, 0);
      step(1, 32'h208, 0, 1, 1);
      step(0, 32'h0, 0, 0, 0);
      step(1, 32'h300, 1, 0, 0);
      step(1, 32'h304, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
